// File: rtl/gnr_node_multi.sv
// Boolean-network node: NUM_CH independent state channels sharing one runtime truth table,
// each with a start-skip counter, a toggle pulse and a saturating toggle counter.
module gnr_node_multi #(
  parameter int NUM_IN = 2,
  parameter int NUM_CH = 2,
  parameter int DW     = 4,
  parameter int CW     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reset_nos,
  input  logic [NUM_CH-1:0]        init_state,
  input  logic [NUM_CH-1:0]        start,
  input  logic [NUM_CH*DW-1:0]     delay_cfg,
  input  logic [2**NUM_IN-1:0]     lut_cfg,
  input  logic [NUM_CH*NUM_IN-1:0] in_bits,
  output logic [NUM_CH-1:0]        state,
  output logic [NUM_CH-1:0]        changed,
  output logic [NUM_CH*CW-1:0]     flip_cnt
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [NUM_IN-1:0] w_idx;
    logic [DW-1:0]     w_dly;
    logic              w_next;
    logic              w_upd;
    logic [DW-1:0]     r_cnt;
    logic              r_state;
    logic              r_chg;
    logic [CW-1:0]     r_flip;

    assign w_idx  = in_bits[k*NUM_IN +: NUM_IN];
    assign w_dly  = delay_cfg[k*DW +: DW];
    assign w_next = lut_cfg[w_idx];
    // Live compare: lowering the delay mid-count releases the very next start.
    assign w_upd  = start[k] && (r_cnt >= w_dly);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= 1'b0;
        r_chg   <= 1'b0;
        r_flip  <= '0;
        r_cnt   <= '0;
      end else if (reset_nos) begin
        r_state <= init_state[k];
        r_chg   <= 1'b0;
        r_flip  <= '0;
        r_cnt   <= '1;
      end else begin
        r_chg <= 1'b0;
        if (w_upd) begin
          r_cnt   <= '0;
          r_state <= w_next;
          if (w_next != r_state) begin
            r_chg <= 1'b1;
            if (r_flip != '1) r_flip <= r_flip + 1'b1;
          end
        end else if (start[k] && r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign state[k]               = r_state;
    assign changed[k]             = r_chg;
    assign flip_cnt[k*CW +: CW]   = r_flip;
  end

endmodule

// File: tb/tb_gnr_node_multi.sv
// Bench for gnr_node_multi (NUM_IN=2, NUM_CH=2, DW=4, CW=2): event-count model plus literal pins.
module tb_gnr_node_multi;
  localparam int NI = 2;
  localparam int NC = 2;
  localparam int DW = 4;
  localparam int CW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             reset_nos = 1'b0;
  logic [NC-1:0]    init_state = '0;
  logic [NC-1:0]    start = '0;
  logic [NC*DW-1:0] delay_cfg = '0;
  logic [2**NI-1:0] lut_cfg = '0;
  logic [NC*NI-1:0] in_bits = '0;
  logic [NC-1:0]    d_state;
  logic [NC-1:0]    d_changed;
  logic [NC*CW-1:0] d_flip;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  gnr_node_multi #(.NUM_IN(NI), .NUM_CH(NC), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start(start), .delay_cfg(delay_cfg), .lut_cfg(lut_cfg), .in_bits(in_bits),
    .state(d_state), .changed(d_changed), .flip_cnt(d_flip)
  );

  always #5 clk = ~clk;

  // Model: starts skipped since the last update (large after reset_nos = ready),
  // and an unbounded toggle count clipped to the counter range on comparison.
  int m_skips [NC];
  int m_togs  [NC];
  bit m_state [NC];
  bit m_chg   [NC];

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < NC; k++) begin
      if (!rst) begin
        m_state[k] <= 1'b0; m_chg[k] <= 1'b0; m_togs[k] <= 0; m_skips[k] <= 0;
      end else if (reset_nos) begin
        m_state[k] <= init_state[k]; m_chg[k] <= 1'b0; m_togs[k] <= 0; m_skips[k] <= 1000;
      end else begin
        m_chg[k] <= 1'b0;
        if (start[k]) begin
          if (m_skips[k] >= int'(delay_cfg[k*DW +: DW])) begin
            m_skips[k] <= 0;
            m_state[k] <= lut_cfg[in_bits[k*NI +: NI]];
            if (lut_cfg[in_bits[k*NI +: NI]] != m_state[k]) begin
              m_chg[k]  <= 1'b1;
              m_togs[k] <= m_togs[k] + 1;
            end
          end else begin
            m_skips[k] <= m_skips[k] + 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("state[%0d]", k), 32'(d_state[k]), 32'(m_state[k]));
        chk($sformatf("changed[%0d]", k), 32'(d_changed[k]), 32'(m_chg[k]));
        chk($sformatf("flip[%0d]", k), 32'(d_flip[k*CW +: CW]),
            (m_togs[k] > 3) ? 32'd3 : 32'(m_togs[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    chk("rst_state", 32'(d_state), 32'd0);
    chk("rst_flip", 32'(d_flip), 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;
    tick();

    // Test 1: index bit0 passes through; ch0 delay 1, ch1 delay 0
    lut_cfg = 4'b1010; delay_cfg = {4'd0, 4'd1};
    init_state = 2'b00; reset_nos = 1'b1;
    tick();
    reset_nos = 1'b0;
    chk("t1_init", 32'(d_state), 32'd0);
    in_bits = 4'b0101; start = 2'b11;
    tick();
    chk("t1_first", 32'(d_state), 32'd3);
    chk("t1_chg", 32'(d_changed), 32'd3);
    repeat (3) tick();
    in_bits = 4'b0000;
    tick();
    chk("t1_fall", 32'(d_state), 32'd0);
    tick();
    chk("t1_flip", 32'(d_flip), 32'b1010);
    repeat (2) tick();

    // Test 5: oscillate ch1 (delay 0) five times; counter pins at 3
    start = 2'b10;
    for (int i = 0; i < 5; i++) begin
      in_bits = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
    end
    chk("t5_flip_sat", 32'(d_flip[3:2]), 32'd3);
    chk("t5_chg", 32'(d_changed[1]), 32'd1);
    start = 2'b00;
    tick();

    // Test 2: async reset mid-run leaves cnt=0, so first start is skipped
    rst = 1'b0;
    #2;
    chk("t2_async", 32'(d_state), 32'd0);
    rst = 1'b1;
    tick();
    delay_cfg = {4'd0, 4'd1}; in_bits = 4'b0001; start = 2'b01;
    tick();
    chk("t2_skip", 32'(d_state[0]), 32'd0);
    tick();
    chk("t2_upd", 32'(d_state[0]), 32'd1);
    start = 2'b00;
    tick();

    // Test 3: reset_nos beats start in the same cycle
    init_state = 2'b11; in_bits = 4'b0000; start = 2'b11; reset_nos = 1'b1;
    tick();
    reset_nos = 1'b0; start = 2'b00;
    chk("t3_state", 32'(d_state), 32'd3);
    chk("t3_flip", 32'(d_flip), 32'd0);
    chk("t3_chg", 32'(d_changed), 32'd0);
    tick();

    // Test 4: XOR table, sweep index with delay 0
    lut_cfg = 4'b0110; delay_cfg = '0; init_state = 2'b00; reset_nos = 1'b1;
    tick();
    reset_nos = 1'b0; start = 2'b11;
    for (int i = 0; i < 4; i++) begin
      in_bits = 4'(i * 5);
      tick();
      chk("t4_state", 32'(d_state[0]), (i == 1 || i == 2) ? 32'd1 : 32'd0);
      chk("t4_chg", 32'(d_changed[0]), (i == 1 || i == 3) ? 32'd1 : 32'd0);
    end
    start = 2'b00;
    tick();

    // Test 6: delay 5, three skips, then lowering delay to 2 releases next start
    delay_cfg = {4'd0, 4'd5}; reset_nos = 1'b1;
    tick();
    reset_nos = 1'b0; start = 2'b01; in_bits = 4'b0001;
    tick();
    chk("t6_first", 32'(d_state[0]), 32'd1);
    in_bits = 4'b0000;
    repeat (3) tick();
    chk("t6_held", 32'(d_state[0]), 32'd1);
    delay_cfg = {4'd0, 4'd2};
    tick();
    chk("t6_upd", 32'(d_state[0]), 32'd0);
    start = 2'b00;
    repeat (2) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
